imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered IF/ID immediate-decode stage for the RISC-V core: accepts fetched instructions with a valid/ready handshake, classifies the instruction format, and produces the sign-extended immediate for every RV32I/RV64I format (I, S, B, U, J). XLEN is parametrised. A 2-entry skid buffer gives full throughput under back-pressure, and a synchronous flush discards in-flight entries on redirect. It sits between the fetch unit and the decode/register-read stage.

## Interface
- XLEN, 32: datapath and immediate width. Legal values: 32 or 64.
- PC_W, 32: program-counter width.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries. Synchronous, highest priority.
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept. Registered.
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  registered instruction
- out_pc  out  PC_W  registered PC
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 unknown
- out_illegal  out  1  opcode not recognised

## Operation
- **Format decode (combinational on in_inst, captured at accept):**
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - I, XLEN=64 only: 0011011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - R, XLEN=64 only: 0111011.
  - Anything else, including inst[1:0]≠11: fmt=7, imm=0, illegal=1. The entry is still forwarded, not dropped.
- **Immediates** (then sign-extended from bit 31 to XLEN):
  - I = inst[31:20]
  - S = {inst[31:25], inst[11:7]}
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U = {inst[31:12], 12'b0}
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R: imm = 0.
- **Storage:** main register M drives out_*. Skid register S holds one extra entry.
- **State machine** (by valid bits), states EMPTY, ONE (M valid), FULL (M and S valid):
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → FULL.
  - ONE + drain, no accept → EMPTY.
  - ONE + accept + drain → ONE, M reloaded from input.
  - FULL + drain → ONE, M←S.
  - FULL never accepts.
- **Signal definitions:**
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - in_ready = !S.valid, registered (next-state value).
- **Flush:** the next edge clears M.valid and S.valid. A same-cycle accept is discarded, and a same-cycle drain still counts downstream. The next state is EMPTY and in_ready=1.
- **Ordering:** entries leave strictly in acceptance order. No duplication and no loss except on flush.

## Timing
- **Reset:**
  - out_valid=0, in_ready=1.
  - out_inst=0, out_pc=0, out_imm=0, out_fmt=0, out_illegal=0.
  - S cleared.
  - Reset asserted mid-transfer drops all entries immediately (asynchronous).
- **Latency:** 1 cycle. An instruction accepted at edge N is on out_* with out_valid=1 after edge N.
- **Throughput:** 1 per cycle while out_ready=1.
- **Back-pressure:** out_ready low for 1 cycle with continuous input absorbs exactly one extra entry into S, and in_ready drops after that edge. in_ready returns to 1 the cycle after S drains.
- **Stability:** out_* are held stable while out_valid=1 and out_ready=0. Contents of invalid entries are don't-care except after reset (zero).
- **Flush + in_valid in the same cycle:** flush wins.
- **XLEN=64:** the 64-bit opcodes above decode as unknown when XLEN=32.

## Test plan
- **Reset:** assert rst_n=0 mid-stream → out_valid=0, in_ready=1, out_imm=0 with no clock edge required.
- **Formats, out_ready=1:**
  - addi 0xFFF00093 → fmt=1, imm=0xFFFFFFFF.
  - sw 0xFE112E23 → fmt=2, imm=0xFFFFFFFC.
  - beq 0xFE000EE3 → fmt=3, imm=0xFFFFFFFC.
  - lui 0x123450B7 → fmt=4, imm=0x12345000.
  - jal 0x0080006F → fmt=5, imm=0x00000008.
  - Each appears exactly 1 cycle after acceptance.
- **Illegal opcode:** 0x00000000 → fmt=7, illegal=1, imm=0, still forwarded. With XLEN=32, addiw 0x0010009B → fmt=7. With XLEN=64 it gives fmt=1 and imm=1.
- **Back-pressure:** stream PCs 0,4,8,12 with out_ready=0 for cycles 2–4.
  - in_ready=0 after S fills.
  - Output order 0,4,8,12 with no loss or duplication.
  - out_* stable while stalled.
- **Flush:** with FULL, assert flush together with in_valid (pc=0x40) → next cycle out_valid=0, in_ready=1. pc 0x40 never appears at the output.
- **Random:** random in_valid, out_ready and flush over 10k cycles, checked against a scoreboard model → order preserved, immediates match the reference decode.

Source files
------------

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered IF/ID stage with RV32I/RV64I immediate decode and a 2-entry skid buffer
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;
    state_t state, state_nx;
    entry_t in_e, m, s;
    logic [2:0] fmt;
    logic signed [31:0] raw;
    logic accept, drain;
    always_comb begin
        fmt = 3'd7;
        case (in_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: fmt = 3'd1;
            7'b0011011: fmt = XLEN == 64 ? 3'd1 : 3'd7;
            7'b0100011: fmt = 3'd2;
            7'b1100011: fmt = 3'd3;
            7'b0110111, 7'b0010111: fmt = 3'd4;
            7'b1101111: fmt = 3'd5;
            7'b0110011: fmt = 3'd0;
            7'b0111011: fmt = XLEN == 64 ? 3'd0 : 3'd7;
            default: fmt = 3'd7;
        endcase
        raw = fmt == 3'd1 ? {{20{in_inst[31]}}, in_inst[31:20]}
            : fmt == 3'd2 ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]}
            : fmt == 3'd3 ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}
            : fmt == 3'd4 ? {in_inst[31:12], 12'b0}
            : fmt == 3'd5 ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}
            : '0;
        in_e = '{inst: in_inst, pc: in_pc, imm: XLEN'(raw), fmt: fmt, illegal: fmt == 3'd7};
    end
    assign out_valid = state != EMPTY;
    assign accept = in_valid & in_ready;
    assign drain = out_valid & out_ready;
    assign out_inst = m.inst;
    assign out_pc = m.pc;
    assign out_imm = m.imm;
    assign out_fmt = m.fmt;
    assign out_illegal = m.illegal;
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: state_nx = accept ? ONE : EMPTY;
            ONE: state_nx = accept && !drain ? FULL : drain && !accept ? EMPTY : ONE;
            FULL: state_nx = drain ? ONE : FULL;
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            in_ready <= 1'b1;
            m <= '0;
            s <= '0;
        end else begin
            state <= state_nx;
            in_ready <= state_nx != FULL;
            if (state == FULL && drain) m <= s;
            else if (accept && (state == EMPTY || drain)) m <= in_e;
            if (accept && state == ONE && !drain) s <= in_e;
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed and randomized checks of imm_decode_stage against a queue model
module tb_imm_decode_stage;
    logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_inst = 0, in_pc = 0;
    logic in_ready, out_valid, out_illegal;
    logic [31:0] out_inst, out_pc, out_imm;
    logic [2:0] out_fmt;
    logic w_in_ready, w_out_valid, w_out_illegal;
    logic [31:0] w_out_inst, w_out_pc;
    logic [63:0] w_out_imm;
    logic [2:0] w_out_fmt;
    int checks = 0, errors = 0;
    logic [63:0] q[$];

    imm_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal));

    imm_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_inst(w_out_inst), .out_pc(w_out_pc), .out_imm(w_out_imm), .out_fmt(w_out_fmt),
        .out_illegal(w_out_illegal));

    always #5 clk = ~clk;

    function automatic void ref_dec(input logic [31:0] i, input bit w64, output logic [2:0] f, output logic [63:0] imm);
        logic [6:0] op;
        longint sx, v;
        op = i[6:0];
        sx = longint'($signed(i));
        if (op inside {7'h03, 7'h13, 7'h67, 7'h0F, 7'h73} || (w64 && op == 7'h1B)) f = 1;
        else if (op == 7'h23) f = 2;
        else if (op == 7'h63) f = 3;
        else if (op inside {7'h37, 7'h17}) f = 4;
        else if (op == 7'h6F) f = 5;
        else if (op == 7'h33 || (w64 && op == 7'h3B)) f = 0;
        else f = 7;
        case (f)
            3'd1: v = sx >>> 20;
            3'd2: v = ((sx >>> 25) * 32) + longint'(i[11:7]);
            3'd3: v = ((sx >>> 31) * 4096) + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            3'd4: v = (sx >>> 12) * 4096;
            3'd5: v = ((sx >>> 31) * 1048576) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default: v = 0;
        endcase
        imm = v;
    endfunction

    task automatic step(input bit v, input bit r, input bit f, input logic [31:0] inst, input logic [31:0] pc,
                        output bit acc, output bit dr);
        in_valid = v; out_ready = r; flush = f; in_inst = inst; in_pc = pc;
        #1;
        acc = in_valid && in_ready;
        dr = out_valid && out_ready;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (dr) void'(q.pop_front());
            if (acc) q.push_back({pc, inst});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a, d;
        for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, a, d);
    endtask

    task automatic test_reset();
        bit a, d;
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_imm !== 0 || out_pc !== 0 || out_inst !== 0 || out_fmt !== 0 || out_illegal !== 0) begin
            errors++; $display("FAIL reset_init: valid=%b ready=%b imm=%h fmt=%0d ill=%b want 0 1 0 0 0", out_valid, in_ready, out_imm, out_fmt, out_illegal);
        end
        rst_n = 1;
        @(negedge clk);
        step(1, 0, 0, 32'hFFF00093, 32'h10, a, d);
        step(1, 0, 0, 32'h123450B7, 32'h14, a, d);
        checks++;
        if (out_valid !== 1 || in_ready !== 0) begin
            errors++; $display("FAIL reset_fill: valid=%b ready=%b want 1 0", out_valid, in_ready);
        end
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 0 || in_ready !== 1 || out_imm !== 0 || out_pc !== 0) begin
            errors++; $display("FAIL reset_async: valid=%b ready=%b imm=%h pc=%h want 0 1 0 0", out_valid, in_ready, out_imm, out_pc);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    logic [31:0] t_inst[9] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'h0080006F,
                               32'h00000000, 32'h0010009B, 32'h00B50533, 32'h00B5053B};
    logic [2:0]  t_f32[9]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd7, 3'd0, 3'd7};
    logic [31:0] t_i32[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h8, 0, 0, 0, 0};
    logic [2:0]  t_f64[9]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1, 3'd0, 3'd0};
    logic [63:0] t_i64[9]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,
                               64'h12345000, 64'h8, 0, 64'h1, 0, 0};

    task automatic test_formats();
        bit a, d;
        for (int k = 0; k < 9; k++) begin
            step(1, 1, 0, t_inst[k], 32'(32'h200 + k * 4), a, d);
            checks++;
            if (out_valid !== 1 || out_pc !== 32'(32'h200 + k * 4) || out_inst !== t_inst[k] || out_fmt !== t_f32[k]
                || out_imm !== t_i32[k] || out_illegal !== (t_f32[k] == 3'd7)) begin
                errors++; $display("FAIL fmt32[%0d]: valid=%b pc=%h fmt=%0d imm=%h ill=%b want fmt=%0d imm=%h",
                                   k, out_valid, out_pc, out_fmt, out_imm, out_illegal, t_f32[k], t_i32[k]);
            end
            checks++;
            if (w_out_valid !== 1 || w_out_fmt !== t_f64[k] || w_out_imm !== t_i64[k] || w_out_illegal !== (t_f64[k] == 3'd7)) begin
                errors++; $display("FAIL fmt64[%0d]: valid=%b fmt=%0d imm=%h ill=%b want fmt=%0d imm=%h",
                                   k, w_out_valid, w_out_fmt, w_out_imm, w_out_illegal, t_f64[k], t_i64[k]);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        logic [31:0] held_pc, held_inst, cur;
        int sent = 0;
        bit a, d, r;
        for (int c = 1; c <= 12; c++) begin
            r = !(c >= 2 && c <= 4);
            if (c == 2) begin held_pc = out_pc; held_inst = out_inst; end
            if (c == 3 || c == 4) begin
                checks++;
                if (out_valid !== 1 || out_pc !== held_pc || out_inst !== held_inst) begin
                    errors++; $display("FAIL bp_stable c%0d: valid=%b pc=%h inst=%h want 1 %h %h", c, out_valid, out_pc, out_inst, held_pc, held_inst);
                end
            end
            cur = out_pc;
            step(sent < 4, r, 0, 32'(32'h00100093 + (sent << 20)), 32'(sent * 4), a, d);
            if (a) sent++;
            if (d) got.push_back(cur);
            if (c == 2 || c == 5) begin
                checks++;
                if (in_ready !== (c == 5)) begin
                    errors++; $display("FAIL bp_ready c%0d: got %b want %b", c, in_ready, c == 5);
                end
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d want 4", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== 32'(k * 4)) begin
                errors++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], k * 4);
            end
        end
        idle(2);
    endtask

    task automatic test_flush();
        bit a, d;
        step(1, 0, 0, 32'h00500093, 32'h100, a, d);
        step(1, 0, 0, 32'h00600093, 32'h104, a, d);
        checks++;
        if (in_ready !== 0 || out_valid !== 1) begin
            errors++; $display("FAIL flush_full: ready=%b valid=%b want 0 1", in_ready, out_valid);
        end
        step(1, 0, 1, 32'h00700093, 32'h40, a, d);
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            errors++; $display("FAIL flush_clear: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 0, 0, a, d);
            checks++;
            if (out_valid !== 0) begin
                errors++; $display("FAIL flush_leak[%0d]: valid=%b pc=%h want valid 0", k, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[13] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
        logic [31:0] r32, inst, pc = 32'h1000;
        logic [2:0] f, f64;
        logic [63:0] imm, imm64, e;
        bit a, d;
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || w_out_valid !== out_valid || w_in_ready !== in_ready) begin
                errors++; $display("FAIL rnd_hs c%0d: valid=%b ready=%b depth=%0d", c, out_valid, in_ready, q.size());
            end
            if (q.size() > 0) begin
                e = q[0];
                ref_dec(e[31:0], 0, f, imm);
                ref_dec(e[31:0], 1, f64, imm64);
                checks++;
                if (out_pc !== e[63:32] || out_inst !== e[31:0] || out_fmt !== f || out_imm !== imm[31:0] || out_illegal !== (f == 3'd7)) begin
                    errors++; $display("FAIL rnd32 c%0d: pc=%h inst=%h fmt=%0d imm=%h want pc=%h inst=%h fmt=%0d imm=%h",
                                       c, out_pc, out_inst, out_fmt, out_imm, e[63:32], e[31:0], f, imm[31:0]);
                end
                checks++;
                if (w_out_pc !== e[63:32] || w_out_inst !== e[31:0] || w_out_fmt !== f64 || w_out_imm !== imm64 || w_out_illegal !== (f64 == 3'd7)) begin
                    errors++; $display("FAIL rnd64 c%0d: fmt=%0d imm=%h want fmt=%0d imm=%h", c, w_out_fmt, w_out_imm, f64, imm64);
                end
            end
            r32 = $urandom();
            inst = $urandom_range(0, 7) == 0 ? r32 : {r32[31:7], ops[$urandom_range(0, 12)]};
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, inst, pc, a, d);
            pc += 4;
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
